// File: rtl/moore_pkg.sv
// Shared encodings for the Moore frame arbiter: FSM state codes, controller states
// and the nominal output signatures.
package moore_pkg;

   localparam logic [1:0] S1 = 2'b00;
   localparam logic [1:0] S2 = 2'b01;
   localparam logic [1:0] S3 = 2'b10;
   localparam logic [1:0] S4 = 2'b11;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ARM  = 3'd1,
      P1   = 3'd2,
      P2   = 3'd3,
      P3   = 3'd4,
      DONE = 3'd5
   } ctrl_state_t;

   localparam logic [2:0] SIG_X1 = 3'b110;
   localparam logic [2:0] SIG_X0 = 3'b100;

endpackage

// File: rtl/moore_frame_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, with wrap.
module rr_arbiter #(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_gnt_c,
   output logic [IDW-1:0]  o_idx_c,
   output logic            o_any_c
);

   logic [IDW-1:0] w_j;

   always_comb begin
      o_gnt_c = '0;
      o_idx_c = '0;
      o_any_c = 1'b0;
      w_j     = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         w_j = IDW'((32'(i_ptr) + k) % NREQ);
         if (!o_any_c && i_req[w_j]) begin
            o_any_c      = 1'b1;
            o_idx_c      = w_j;
            o_gnt_c[w_j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/moore_frame_arbiter.sv
// Round-robin scheduler that time-shares one free-running Moore FSM: aligns each grant
// to S1, drives the winner's X for that cycle and captures a 3-bit output signature.
module moore_frame_arbiter
   import moore_pkg::*;
#(
   parameter  int unsigned NREQ    = 4,
   parameter  int unsigned TIMEOUT = 7,
   localparam int unsigned IDW     = $clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [NREQ-1:0] req_x,
   input  logic [1:0]      fsm_state,
   input  logic            fsm_outp,
   output logic            fsm_x,
   output logic            busy,
   output logic [NREQ-1:0] gnt,
   output logic            done,
   output logic [2:0]      result,
   output logic [IDW-1:0]  res_id,
   output logic            err
);

   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   ctrl_state_t     r_state;
   logic [IDW-1:0]  r_ptr;
   logic [IDW-1:0]  r_id;
   logic            r_x;
   logic [TW-1:0]   r_tmo;
   logic [2:0]      r_cap;

   logic [NREQ-1:0] w_gnt;
   logic [IDW-1:0]  w_idx;
   logic            w_any;
   logic            w_s1_cycle;
   logic [1:0]      w_exp_mid;
   logic [IDW-1:0]  w_next_ptr;

   rr_arbiter #(.NREQ(NREQ)) u_rr (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_gnt_c (w_gnt),
      .o_idx_c (w_idx),
      .o_any_c (w_any)
   );

   // The ARM cycle that sees S1 doubles as the P1 cycle, so X goes out immediately.
   assign w_s1_cycle = (r_state == P1) || ((r_state == ARM) && (fsm_state == S1));
   assign fsm_x      = w_s1_cycle & r_x;
   assign w_exp_mid  = r_x ? S2 : S3;
   assign w_next_ptr = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_id    <= '0;
         r_x     <= 1'b0;
         r_tmo   <= '0;
         r_cap   <= '0;
         busy    <= 1'b0;
         gnt     <= '0;
         done    <= 1'b0;
         result  <= '0;
         res_id  <= '0;
         err     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  gnt     <= w_gnt;
                  r_id    <= w_idx;
                  r_x     <= req_x[w_idx];
                  busy    <= 1'b1;
                  r_tmo   <= '0;
                  r_cap   <= '0;
                  r_state <= ARM;
               end
            end
            ARM: begin
               if (fsm_state == S1) begin
                  r_cap[2] <= fsm_outp;
                  r_state  <= P2;
               end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                  done    <= 1'b1;
                  err     <= 1'b1;
                  result  <= r_cap;
                  res_id  <= r_id;
                  r_state <= DONE;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
            P1: begin
               r_cap[2] <= fsm_outp;
               r_state  <= P2;
            end
            P2: begin
               if (fsm_state == w_exp_mid) begin
                  r_cap[1] <= fsm_outp;
                  r_state  <= P3;
               end else begin
                  done    <= 1'b1;
                  err     <= 1'b1;
                  result  <= r_cap;
                  res_id  <= r_id;
                  r_state <= DONE;
               end
            end
            P3: begin
               done    <= 1'b1;
               res_id  <= r_id;
               r_state <= DONE;
               if (fsm_state == S4) begin
                  err    <= 1'b0;
                  result <= {r_cap[2:1], fsm_outp};
               end else begin
                  err    <= 1'b1;
                  result <= {r_cap[2:1], 1'b0};
               end
            end
            DONE: begin
               gnt     <= '0;
               busy    <= 1'b0;
               r_ptr   <= w_next_ptr;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_moore_frame_arbiter.sv
// Bench for moore_frame_arbiter: behavioural shared FSM plus a transaction-level
// round-robin/signature reference model, directed steps then random requests.
module tb_moore_frame_arbiter;
   import moore_pkg::*;

   localparam int unsigned NREQ = 4;

   logic            clk;
   logic            rst;
   logic [NREQ-1:0] req;
   logic [NREQ-1:0] req_x;
   logic [1:0]      fsm_state;
   logic            fsm_outp;
   logic            fsm_x;
   logic            busy;
   logic [NREQ-1:0] gnt;
   logic            done;
   logic [2:0]      result;
   logic [1:0]      res_id;
   logic            err;

   logic [1:0]      m_state = 2'b00;
   logic            ovr_en;
   logic [1:0]      ovr_state;
   logic            inj_en;

   int total;
   int bad;
   int mptr;

   moore_frame_arbiter #(.NREQ(NREQ), .TIMEOUT(7)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_x     (req_x),
      .fsm_state (fsm_state),
      .fsm_outp  (fsm_outp),
      .fsm_x     (fsm_x),
      .busy      (busy),
      .gnt       (gnt),
      .done      (done),
      .result    (result),
      .res_id    (res_id),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Shared Moore FSM: outp is 1 in S1 and S2, so x=1 gives 110 and x=0 gives 100.
   always @(posedge clk) begin
      case (m_state)
         2'b00:   m_state <= (inj_en && busy) ? 2'b01 : (fsm_x ? 2'b01 : 2'b10);
         2'b01:   m_state <= 2'b11;
         2'b10:   m_state <= 2'b11;
         default: m_state <= 2'b00;
      endcase
   end

   assign fsm_state = ovr_en ? ovr_state : m_state;
   assign fsm_outp  = (fsm_state == 2'b00) || (fsm_state == 2'b01);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] m, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (m[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return 0;
   endfunction

   // Waits for one done pulse and checks everything the reference model predicts for it.
   task automatic serve(input string tag, input int exp_id, input logic [2:0] exp_res,
                        input logic exp_err, input logic exp_x, input logic exp_s1,
                        input logic chk_seq, input int min_lat, input int max_lat);
      int   lat;
      bit   seen;
      bit   got_s1;
      bit   take_next;
      bit   s1_now;
      int   xbad;
      logic xs1;
      logic [1:0] nxt;
      lat = 0; seen = 0; got_s1 = 0; take_next = 0; xbad = 0; xs1 = 1'b0; nxt = 2'b00;
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         s1_now = 0;
         if (done) begin
            seen = 1;
         end else begin
            if (take_next) begin
               nxt       = fsm_state;
               take_next = 0;
            end
            if (!got_s1 && busy && fsm_state == S1) begin
               s1_now    = 1;
               got_s1    = 1;
               take_next = 1;
               xs1       = fsm_x;
            end
         end
         if (fsm_x && !s1_now) xbad++;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'(1));
      if (seen) begin
         check({tag, "_res_id"}, 32'(res_id), 32'(exp_id));
         check({tag, "_result"}, 32'(result), 32'(exp_res));
         check({tag, "_err"},    32'(err),    32'(exp_err));
         check({tag, "_gnt"},    32'(gnt),    32'(4'(1) << exp_id));
         check({tag, "_busy"},   32'(busy),   32'(1));
         check({tag, "_lat_ok"}, 32'(lat >= min_lat && lat <= max_lat), 32'(1));
      end
      check({tag, "_saw_s1"}, 32'(got_s1), 32'(exp_s1));
      check({tag, "_x_stray"}, 32'(xbad), 32'(0));
      if (exp_s1) check({tag, "_x_in_s1"}, 32'(xs1), 32'(exp_x));
      if (chk_seq) check({tag, "_mid_state"}, 32'(nxt), 32'(exp_x ? S2 : S3));
   endtask

   initial begin
      int   ids[5];
      int   id;
      int   steps;
      int   done_cnt;
      logic [NREQ-1:0] m;
      logic [NREQ-1:0] xs;
      total = 0; bad = 0; mptr = 0;
      clk = 1'b0; rst = 1'b1;
      req = '0; req_x = '0; ovr_en = 1'b0; ovr_state = 2'b00; inj_en = 1'b0;
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy",   32'(busy),   32'(0));
      check("rst_gnt",    32'(gnt),    32'(0));
      check("rst_done",   32'(done),   32'(0));
      check("rst_result", 32'(result), 32'(0));
      check("rst_res_id", 32'(res_id), 32'(0));
      check("rst_err",    32'(err),    32'(0));
      check("rst_fsm_x",  32'(fsm_x),  32'(0));
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Single requester 0 with x=1.
      req = 4'b0001; req_x = 4'b0001;
      serve("r0_x1", 0, SIG_X1, 1'b0, 1'b1, 1'b1, 1'b1, 4, 7);
      req = '0; mptr = 1;
      @(negedge clk);

      // Requester 2 with x=0: FSM must take the S3 branch.
      req = 4'b0100; req_x = 4'b0000;
      serve("r2_x0", 2, SIG_X0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 7);
      req = '0; mptr = 3;
      @(negedge clk);

      // FSM stuck in S2 while armed: timeout after seven ARM cycles.
      ovr_en = 1'b1; ovr_state = 2'b01;
      req = 4'b0010; req_x = 4'b0010;
      serve("tmo", 1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 8, 8);
      req = '0; ovr_en = 1'b0; mptr = 2;
      @(negedge clk);

      // S2 injected where S3 is due for x=0: sequence error.
      inj_en = 1'b1;
      req = 4'b1000; req_x = 4'b0000;
      serve("inject", 3, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 4, 7);
      req = '0; inj_en = 1'b0; mptr = 0;
      @(negedge clk);

      // Normal service after the error; err must clear.
      req = 4'b0001; req_x = 4'b0000;
      serve("post_err", 0, SIG_X0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 7);
      req = '0; mptr = 1;
      @(negedge clk);

      // Reset asserted in the cycle after the frame's S1 cycle.
      req = 4'b0100; req_x = 4'b0100;
      steps = 0;
      while (steps < 20 && !(busy && fsm_state == S1)) begin
         @(negedge clk);
         steps++;
      end
      check("rstmid_found_s1", 32'(steps < 20), 32'(1));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmid_busy",   32'(busy),   32'(0));
      check("rstmid_gnt",    32'(gnt),    32'(0));
      check("rstmid_result", 32'(result), 32'(0));
      check("rstmid_err",    32'(err),    32'(0));
      check("rstmid_fsm_x",  32'(fsm_x),  32'(0));
      req = '0;
      done_cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("rstmid_no_done", 32'(done_cnt), 32'(0));
      rst = 1'b1; mptr = 0;
      @(negedge clk);

      // All four held: strict rotation from pointer 0.
      req = 4'b1111; req_x = 4'b0101;
      for (int i = 0; i < 5; i++) begin
         ids[i] = (mptr + i) % NREQ;
      end
      for (int i = 0; i < 5; i++) begin
         serve($sformatf("rr%0d", i), ids[i], req_x[ids[i]] ? SIG_X1 : SIG_X0, 1'b0,
               req_x[ids[i]], 1'b1, 1'b1, 4, 8);
      end
      req = '0; mptr = 1;
      @(negedge clk);

      req = 4'b0010; req_x = 4'b0000;
      serve("r1_after_rr", 1, SIG_X0, 1'b0, 1'b0, 1'b1, 1'b1, 4, 7);
      req = '0; mptr = 2;
      @(negedge clk);

      // Random masks and X values against the round-robin model.
      for (int t = 0; t < 16; t++) begin
         m  = 4'($urandom_range(1, 15));
         xs = 4'($urandom);
         id = pick(m, mptr);
         req = m; req_x = xs;
         serve($sformatf("rand%0d", t), id, xs[id] ? SIG_X1 : SIG_X0, 1'b0, xs[id],
               1'b1, 1'b1, 4, 7);
         req = '0;
         mptr = (id + 1) % NREQ;
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/moore_frame_arbiter.md
Name: moore_frame_arbiter

Overview:
Round-robin scheduler sharing one free-running 4-state Moore FSM (S1→S2|S3→S4→S1, X sampled in S1) among NREQ requesters. Per grant it aligns to S1, drives the winner's X bit for that cycle, captures the FSM output over one full 3-cycle frame, and returns the 3-bit output signature with a done/err pulse. Sits between requester logic and the shared FSM instance; the FSM's X input is driven only by this block.

Parameters:
NREQ, 4, number of requesters (2..8)
TIMEOUT, 7, max cycles spent waiting for S1 before abort with err

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
req  in  NREQ  per-requester request level, held until own done
req_x  in  NREQ  per-requester X value to present in S1
fsm_state  in  2  current state of shared FSM (S1=00,S2=01,S3=10,S4=11)
fsm_outp  in  1  Moore output of shared FSM
fsm_x  out  1  X drive into shared FSM
busy  out  1  frame in progress (ARM..P3)
gnt  out  NREQ  one-hot grant, held from ARM through DONE
done  out  1  one-cycle pulse, result/res_id/err valid
result  out  3  captured outp: [2]=S1 cycle, [1]=S2/S3 cycle, [0]=S4 cycle
res_id  out  log2(NREQ)  index of serviced requester
err  out  1  qualifies done: sequence mismatch or timeout

Behaviour:
- Reset (rst=0, async): ctrl→IDLE; fsm_x, busy, gnt, done, result, res_id, err = 0; rr pointer = 0. Reset mid-frame aborts silently (no done).
- Controller states: IDLE, ARM, P1, P2, P3, DONE.
- IDLE: if |req, choose first set req at/after rr pointer (wrap-around); register winner id, x_lat = req_x[id]; gnt one-hot; →ARM. Else stay.
- ARM: busy=1; timeout counter counts ARM cycles. If fsm_state==S1 → P1 in the same cycle's evaluation (fsm_x=x_lat, result[2]=fsm_outp captured at edge). Counter reaching TIMEOUT without S1 → DONE with err=1.
- P1 (FSM in S1 this cycle): fsm_x=x_lat combinationally; capture result[2]; →P2.
- P2: expected state = S2 if x_lat=1 else S3; on match capture result[1], →P3; mismatch → DONE with err=1.
- P3: expected S4; match → capture result[0], →DONE; mismatch → err=1, →DONE.
- DONE: done=1 one cycle, res_id valid, gnt still asserted; rr pointer = id+1 mod NREQ; →IDLE; gnt, busy cleared next cycle.
- fsm_x = 0 in every state except P1 cycle (ARM cycle where S1 is detected counts as P1).
- Latency: grant to done = wait-for-S1 (0..3 cycles normal) + 3 frame cycles + 1.
- result/res_id/err hold last values until next DONE; err cleared on a successful DONE.
- req dropped by winner mid-frame: frame completes anyway, result delivered. req of others ignored while busy.
- Nominal signatures: x=1 → 3'b110, x=0 → 3'b100.
- Back-to-back: IDLE re-arbitrates the cycle after DONE; earliest next P1 is next S1 after that.

Decomposition:
- Package moore_pkg: S1..S4 2-bit encodings, ctrl_state_t enum (IDLE,ARM,P1,P2,P3,DONE), SIG_X1=3'b110, SIG_X0=3'b100.
- Sub-module rr_arbiter (req, pointer → one-hot grant + index, combinational); controller FSM and capture regs in top.

Test Plan:
- Single req[0]=1, req_x[0]=1, FSM free-running → fsm_x=1 only during S1 cycle, done with result=3'b110, res_id=0, err=0.
- req[2]=1, req_x[2]=0 → result=3'b100, res_id=2; next frame FSM goes S1→S3 observed.
- req=4'b1111 held, req_x=4'b0101 → grants served in order 0,1,2,3,0; results 110,100,110,100; no starvation.
- Forced fsm_state stuck at 01 in ARM → after 7 cycles done=1, err=1, fsm_x never asserted.
- Inject S2 instead of S3 during P2 with x=0 → done, err=1, next request still served normally.
- Assert rst=0 during P2 → all outputs 0 immediately, no done; after release req[1] served with rr pointer 0.
